pixel_write_demux: RTL
======================

Name: pixel_write_demux

Overview:
- Routes one stream of pixel-write beats {x, y, colour} from the game logic to one of N_DEST consumers, selected per beat by a destination tag. Default consumers: board memory, next-piece preview, score panel.
- It is the fan-out counterpart of the selection muxes in the datapath. One source feeds many sinks.
- Each port uses a valid/ready handshake.
- A registered two-entry skid buffer gives full throughput with one cycle of latency.
- Per-destination beat counters and a drop counter support debug on the HEX displays.

Parameters:
- DATA_W, 18, beat payload width: x[17:10] (8 bits), y[9:3] (7 bits), colour[2:0].
- N_DEST, 3, number of destinations. Must be 2 to 4.
- SEL_W, 2, destination tag width.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- in_valid  input  1  source has a beat.
- in_ready  output  1  block can accept a beat.
- in_data  input  DATA_W  beat payload.
- in_sel  input  SEL_W  destination tag for this beat.
- out_data  output  DATA_W  payload of the head beat, shared by all destinations.
- out_valid  output  N_DEST  one-hot or zero; bit k high means the head beat is for destination k.
- out_ready  input  N_DEST  per-destination ready.
- cnt_clear  input  1  synchronous clear of all counters.
- beat_cnt  output  N_DEST*CNT_W  flattened per-destination delivered-beat counters; destination k occupies bits [k*CNT_W +: CNT_W].
- drop_cnt  output  CNT_W  count of beats dropped for an illegal tag.
- drop_pulse  output  1  one-cycle pulse, high the cycle after an illegal beat is accepted.

Behaviour:
- Reset (resetn low, asynchronous): both buffer entries empty, out_valid = 0, out_data = 0, in_ready = 1, all counters 0, drop_pulse = 0. When resetn goes low mid-transfer, buffered beats are discarded and not counted.
- Storage:
  - MAIN entry: valid, data, sel. Drives out_data and out_valid.
  - SKID entry: valid, data, sel.
  - in_ready is a register equal to ~SKID.valid. It never depends combinationally on out_ready.
- Accept: in_valid & in_ready on a rising edge.
- Illegal tag (in_sel >= N_DEST): the beat is accepted, consumes one handshake, and is discarded. It never enters MAIN or SKID. drop_pulse = 1 on the next cycle. drop_cnt increments, saturating at all-ones.
- Pop: MAIN.valid & out_ready[MAIN.sel]. The out_ready bits of other destinations are ignored. A sink may not stall beats addressed to another sink.
- out_valid[k] = MAIN.valid & (MAIN.sel == k). Registered, so at most one bit is set.
- Once out_valid[k] is high, out_data and out_valid stay stable until popped.
- Latency: a legal beat accepted at edge t is presented at MAIN from edge t onward, i.e. visible in the cycle after t. Minimum latency is 1 cycle.
- Next-state cases for a legal accept:
  - MAIN empty, or MAIN popping with SKID empty: the beat loads MAIN.
  - MAIN full, not popping, SKID empty: the beat loads SKID and in_ready falls.
  - Pop with SKID full: SKID moves to MAIN and in_ready rises. No accept is possible that cycle, because in_ready was 0.
- Ordering: beats are delivered in strict acceptance order across all destinations. A stalled destination at the head blocks every later beat (head-of-line blocking is intended).
- Throughput: with out_ready held high, one beat per cycle is sustained indefinitely.
- Counters:
  - beat_cnt[k] increments on each pop to destination k and saturates at 2^CNT_W - 1.
  - cnt_clear zeroes all counters and overrides a same-cycle increment. Buffer state is unaffected.
- No combinational path from in_* to out_*.

Test Plan:
- Reset, then 4 beats with sel = 0,1,2,0 and out_ready = 3'b111 held → out_valid sequence 001, 010, 100, 001 on consecutive cycles starting one cycle after the first accept. beat_cnt = {1,1,2} (dest2, dest1, dest0). in_ready stays 1.
- Stall: out_ready[1] = 0, send sel = 1 (data 0x00ABC) then sel = 0 (data 0x00123) → 0x00ABC held on out_valid = 010. Second beat sits in SKID and in_ready = 0. Raising out_ready[1] delivers 0x00ABC, then 0x00123 on 001 the next cycle, and in_ready returns to 1.
- Illegal tag: sel = 3 with N_DEST = 3 → beat accepted, out_valid remains 0, drop_pulse high for exactly 1 cycle, drop_cnt = 1.
- Saturation with CNT_W = 4: 20 pops to dest 2 → beat_cnt[2] = 15. Assert cnt_clear → all counters 0 next cycle.
- Reset mid-transfer: with both entries full, pull resetn low asynchronously between edges → out_valid = 0 and in_ready = 1 immediately. Counters 0. No stale beat appears after release.
- Random 10k beats with random out_ready against a scoreboard → per-destination order and data match, no loss or duplication, beat_cnt totals match.

Source files
------------

// File: rtl/pixel_write_demux.sv
// Pixel-write fan-out: one beat stream routed to N_DEST sinks by tag,
// through a two-entry skid buffer, with per-sink and drop counters.
module pixel_write_demux #(
    parameter int DATA_W = 18,
    parameter int N_DEST = 3,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [SEL_W-1:0]        in_sel,
    output logic [DATA_W-1:0]       out_data,
    output logic [N_DEST-1:0]       out_valid,
    input  logic [N_DEST-1:0]       out_ready,
    input  logic                    cnt_clear,
    output logic [N_DEST*CNT_W-1:0] beat_cnt,
    output logic [CNT_W-1:0]        drop_cnt,
    output logic                    drop_pulse
);

    logic              r_main_v;
    logic [DATA_W-1:0] r_main_d;
    logic [SEL_W-1:0]  r_main_s;
    logic              r_skid_v;
    logic [DATA_W-1:0] r_skid_d;
    logic [SEL_W-1:0]  r_skid_s;
    logic              r_in_ready;
    logic              r_drop_pulse;
    logic [CNT_W-1:0]  r_drop_cnt;
    logic [CNT_W-1:0]  r_beat_cnt [N_DEST];

    logic              w_acc;
    logic              w_legal;
    logic              w_drop;
    logic              w_pop;
    logic [N_DEST-1:0] w_hit;
    logic [N_DEST-1:0] w_pop_vec;

    // Tag decode of the head entry; only the addressed sink's ready counts.
    genvar k;
    generate
        for (k = 0; k < N_DEST; k++) begin : g_dec
            assign w_hit[k]     = r_main_v & (r_main_s == SEL_W'(k));
            assign w_pop_vec[k] = w_hit[k] & out_ready[k];
        end
    endgenerate

    assign w_pop   = |w_pop_vec;
    assign w_acc   = in_valid & r_in_ready;
    assign w_legal = ({1'b0, in_sel} < (SEL_W+1)'(N_DEST));
    assign w_drop  = w_acc & ~w_legal;

    assign in_ready   = r_in_ready;
    assign out_data   = r_main_d;
    assign out_valid  = w_hit;
    assign drop_cnt   = r_drop_cnt;
    assign drop_pulse = r_drop_pulse;

    // Skid buffer: refill MAIN from SKID first, else from the input.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_main_v   <= 1'b0;
            r_main_d   <= '0;
            r_main_s   <= '0;
            r_skid_v   <= 1'b0;
            r_skid_d   <= '0;
            r_skid_s   <= '0;
            r_in_ready <= 1'b1;
        end else if (w_pop && r_skid_v) begin
            r_main_d   <= r_skid_d;
            r_main_s   <= r_skid_s;
            r_skid_v   <= 1'b0;
            r_in_ready <= 1'b1;
        end else if (w_acc && w_legal) begin
            if (!r_main_v || w_pop) begin
                r_main_v <= 1'b1;
                r_main_d <= in_data;
                r_main_s <= in_sel;
            end else begin
                r_skid_v   <= 1'b1;
                r_skid_d   <= in_data;
                r_skid_s   <= in_sel;
                r_in_ready <= 1'b0;
            end
        end else if (w_pop) begin
            r_main_v <= 1'b0;
        end
    end

    // Illegal-tag beats are swallowed; flag them and count, saturating.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_drop_pulse <= 1'b0;
            r_drop_cnt   <= '0;
        end else begin
            r_drop_pulse <= w_drop;
            if (cnt_clear)
                r_drop_cnt <= '0;
            else if (w_drop && !(&r_drop_cnt))
                r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    generate
        for (k = 0; k < N_DEST; k++) begin : g_cnt
            // Delivered-beat counter for sink k; clear beats increment.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn)
                    r_beat_cnt[k] <= '0;
                else if (cnt_clear)
                    r_beat_cnt[k] <= '0;
                else if (w_pop_vec[k] && !(&r_beat_cnt[k]))
                    r_beat_cnt[k] <= r_beat_cnt[k] + 1'b1;
            end
            assign beat_cnt[k*CNT_W +: CNT_W] = r_beat_cnt[k];
        end
    endgenerate

endmodule
